dbus_arbiter: RTL and testbench

- Two-master, one-slave arbiter for the D-bus.
- Lets the rv_core data port and the debug module's system-bus port share the single downstream D-bus that feeds the D-bus interconnect (memory, GPIO, CLINT).
- Arbitration is either fixed debug-priority or round-robin.
- Slave accesses are bounded by a timeout, so a hung slave cannot lock out the debugger.

---
 rtl/dbus_arb_pkg.sv | 23 ++
 rtl/dbus_arb_timer.sv | 32 +++
 rtl/dbus_arbiter.sv | 138 +++++++++++++
 tb/tb_dbus_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dbus_arb_pkg.sv
// Shared types and encodings for the two-master D-bus arbiter.
package dbus_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_CORE = 2'd1,
        ARB_DM   = 2'd2
    } arb_state_t;

    localparam logic [1:0]  OWNER_NONE = 2'b00;
    localparam logic [1:0]  OWNER_CORE = 2'b01;
    localparam logic [1:0]  OWNER_DM   = 2'b10;
    localparam logic [31:0] ERR_RDATA  = 32'h0;

    function automatic logic [1:0] owner_of(input arb_state_t s);
        case (s)
            ARB_CORE: owner_of = OWNER_CORE;
            ARB_DM:   owner_of = OWNER_DM;
            default:  owner_of = OWNER_NONE;
        endcase
    endfunction

endpackage

// File: rtl/dbus_arb_timer.sv
// Wait counter for a granted access; tc flags the last cycle before abort.
module dbus_arb_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/dbus_arbiter.sv
// Two-master (core, debug module) to one-slave D-bus arbiter with
// fixed or round-robin priority and a slave-ack timeout.
module dbus_arbiter
    import dbus_arb_pkg::*;
#(
    parameter int unsigned RR_MODE = 0,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    input  logic [3:0]  c_wstrb,
    output logic        c_ack,
    output logic        c_err,
    output logic [31:0] c_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_ack,
    output logic        d_err,
    output logic [31:0] d_rdata,
    output logic        s_req,
    output logic        s_we,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ack,
    input  logic [31:0] s_rdata,
    output logic [1:0]  owner
);
    arb_state_t  state_q, state_d;
    logic [1:0]  owner_q, owner_d;
    logic        last_dm_q, last_dm_d;
    logic        granted, done, abort, tc;
    logic        own_core, own_dm;
    logic        resp_ack, resp_err;
    logic [31:0] resp_rdata;

    assign own_core = (owner_q == OWNER_CORE);
    assign own_dm   = (owner_q == OWNER_DM);
    assign granted  = own_core | own_dm;
    assign done     = granted & s_ack;
    // s_ack has priority over the terminal count
    assign abort    = granted & ~s_ack & tc;

    dbus_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (~granted | done | abort),
        .en  (granted & ~s_ack),
        .tc  (tc)
    );

    always_comb begin
        state_d   = state_q;
        last_dm_d = last_dm_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (c_req && d_req) begin
                    state_d = (RR_MODE != 0 && last_dm_q) ? ARB_CORE : ARB_DM;
                end else if (c_req) begin
                    state_d = ARB_CORE;
                end else if (d_req) begin
                    state_d = ARB_DM;
                end
            end
            ARB_CORE: begin
                if (done) begin
                    last_dm_d = 1'b0;
                    state_d   = d_req ? ARB_DM : ARB_IDLE;
                end else if (abort) begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_DM: begin
                if (done) begin
                    last_dm_d = 1'b1;
                    state_d   = c_req ? ARB_CORE : ARB_IDLE;
                end else if (abort) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        owner_d = owner_of(state_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ARB_IDLE;
            owner_q   <= OWNER_NONE;
            last_dm_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_dm_q <= last_dm_d;
        end
    end

    always_comb begin
        s_req   = 1'b0;
        s_we    = 1'b0;
        s_addr  = '0;
        s_wdata = '0;
        s_wstrb = '0;
        if (own_core) begin
            s_req   = c_req;
            s_we    = c_we;
            s_addr  = c_addr;
            s_wdata = c_wdata;
            s_wstrb = c_wstrb;
        end else if (own_dm) begin
            s_req   = d_req;
            s_we    = d_we;
            s_addr  = d_addr;
            s_wdata = d_wdata;
            s_wstrb = d_wstrb;
        end
    end

    assign resp_ack   = done | abort;
    assign resp_err   = abort;
    assign resp_rdata = abort ? ERR_RDATA : s_rdata;

    assign c_ack   = own_core & resp_ack;
    assign c_err   = own_core & resp_err;
    assign c_rdata = own_core ? resp_rdata : '0;
    assign d_ack   = own_dm & resp_ack;
    assign d_err   = own_dm & resp_err;
    assign d_rdata = own_dm ? resp_rdata : '0;
    assign owner   = owner_q;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Bench for dbus_arbiter: two configurations share stimulus; a per-cycle
// reference model checks both, with directed scenarios pinning literals.
module tb_dbus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_req, c_we, d_req, d_we, s_ack;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata, s_rdata;
    logic [3:0]  c_wstrb, d_wstrb;

    logic        c_ack [2];
    logic        c_err [2];
    logic        d_ack [2];
    logic        d_err [2];
    logic        s_req [2];
    logic        s_we  [2];
    logic [31:0] c_rdata [2];
    logic [31:0] d_rdata [2];
    logic [31:0] s_addr  [2];
    logic [31:0] s_wdata [2];
    logic [3:0]  s_wstrb [2];
    logic [1:0]  owner   [2];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dbus_arbiter #(.RR_MODE(0), .TIMEOUT(4)) dut0 (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_wstrb(c_wstrb),
        .c_ack(c_ack[0]), .c_err(c_err[0]), .c_rdata(c_rdata[0]),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_ack(d_ack[0]), .d_err(d_err[0]), .d_rdata(d_rdata[0]),
        .s_req(s_req[0]), .s_we(s_we[0]), .s_addr(s_addr[0]), .s_wdata(s_wdata[0]),
        .s_wstrb(s_wstrb[0]), .s_ack(s_ack), .s_rdata(s_rdata), .owner(owner[0])
    );

    dbus_arbiter #(.RR_MODE(1), .TIMEOUT(6)) dut1 (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_wstrb(c_wstrb),
        .c_ack(c_ack[1]), .c_err(c_err[1]), .c_rdata(c_rdata[1]),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_ack(d_ack[1]), .d_err(d_err[1]), .d_rdata(d_rdata[1]),
        .s_req(s_req[1]), .s_we(s_we[1]), .s_addr(s_addr[1]), .s_wdata(s_wdata[1]),
        .s_wstrb(s_wstrb[1]), .s_ack(s_ack), .s_rdata(s_rdata), .owner(owner[1])
    );

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: who holds the bus (0 none, 1 core, 2 debug), how many
    // grant cycles have passed without s_ack, and who was served last.
    int m_own  [2];
    int m_wait [2];
    bit m_last_dm [2];

    always @(negedge clk) begin
        int          to, own, other;
        bit          rr, tmo, r_ack;
        logic        e_req, e_we;
        logic [31:0] e_addr, e_wdata, r_data;
        logic [3:0]  e_wstrb;
        for (int k = 0; k < 2; k++) begin
            to = (k == 0) ? 4 : 6;
            rr = (k == 1);
            if (rst) begin
                m_own[k] = 0; m_wait[k] = 0; m_last_dm[k] = 1'b0;
            end
            own = m_own[k];
            e_req = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0; e_wstrb = '0;
            if (own == 1) begin
                e_req = c_req; e_we = c_we; e_addr = c_addr; e_wdata = c_wdata; e_wstrb = c_wstrb;
            end else if (own == 2) begin
                e_req = d_req; e_we = d_we; e_addr = d_addr; e_wdata = d_wdata; e_wstrb = d_wstrb;
            end
            tmo    = (own != 0) && !s_ack && (m_wait[k] == to - 1);
            r_ack  = (own != 0) && (s_ack || tmo);
            r_data = tmo ? 32'h0 : s_rdata;

            cmp($sformatf("k%0d owner", k), 32'(owner[k]), 32'(own));
            cmp($sformatf("k%0d s_req", k), 32'(s_req[k]), 32'(e_req));
            cmp($sformatf("k%0d s_we", k), 32'(s_we[k]), 32'(e_we));
            cmp($sformatf("k%0d s_addr", k), s_addr[k], e_addr);
            cmp($sformatf("k%0d s_wdata", k), s_wdata[k], e_wdata);
            cmp($sformatf("k%0d s_wstrb", k), 32'(s_wstrb[k]), 32'(e_wstrb));
            cmp($sformatf("k%0d c_ack", k), 32'(c_ack[k]), 32'(own == 1 && r_ack));
            cmp($sformatf("k%0d c_err", k), 32'(c_err[k]), 32'(own == 1 && tmo));
            cmp($sformatf("k%0d c_rdata", k), c_rdata[k], (own == 1) ? r_data : 32'h0);
            cmp($sformatf("k%0d d_ack", k), 32'(d_ack[k]), 32'(own == 2 && r_ack));
            cmp($sformatf("k%0d d_err", k), 32'(d_err[k]), 32'(own == 2 && tmo));
            cmp($sformatf("k%0d d_rdata", k), d_rdata[k], (own == 2) ? r_data : 32'h0);

            if (!rst) begin
                if (own == 0) begin
                    m_wait[k] = 0;
                    if (c_req && d_req) m_own[k] = (rr && m_last_dm[k]) ? 1 : 2;
                    else if (c_req)     m_own[k] = 1;
                    else if (d_req)     m_own[k] = 2;
                end else if (s_ack) begin
                    m_last_dm[k] = (own == 2);
                    other = 3 - own;
                    m_own[k] = ((other == 1) ? c_req : d_req) ? other : 0;
                    m_wait[k] = 0;
                end else if (tmo) begin
                    m_own[k] = 0;
                    m_wait[k] = 0;
                end else begin
                    m_wait[k] = m_wait[k] + 1;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pct;
        rst = 1'b1;
        c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0; c_wstrb = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        s_ack = 0; s_rdata = '0;

        @(negedge clk);
        cmp("reset owner", 32'(owner[0]), 32'h0);
        cmp("reset s_req", 32'(s_req[0]), 32'h0);
        cyc(); rst = 1'b0;
        cyc();

        // Core-only read, slave acks in grant cycle 2
        c_req = 1; c_addr = 32'h0000_0100; c_wstrb = 4'hf;
        @(negedge clk); cmp("d1 idle owner", 32'(owner[0]), 32'h0);
        cyc(); @(negedge clk);
        cmp("d1 grant owner", 32'(owner[0]), 32'h1);
        cmp("d1 grant s_req", 32'(s_req[0]), 32'h1);
        cmp("d1 grant c_ack", 32'(c_ack[0]), 32'h0);
        cyc(); s_ack = 1; s_rdata = 32'hCAFE_0001; @(negedge clk);
        cmp("d1 c_ack", 32'(c_ack[0]), 32'h1);
        cmp("d1 c_rdata", c_rdata[0], 32'hCAFE_0001);
        cmp("d1 d_ack", 32'(d_ack[0]), 32'h0);
        cyc(); c_req = 0; s_ack = 0; s_rdata = '0; @(negedge clk);
        cmp("d1 end owner", 32'(owner[0]), 32'h0);

        // Simultaneous requests, fixed priority, zero-wait slave
        cyc(); c_req = 1; d_req = 1; d_addr = 32'h0000_0200; @(negedge clk);
        cyc(); s_ack = 1; @(negedge clk);
        cmp("d2 dm first", 32'(owner[0]), 32'h2);
        cmp("d2 d_ack", 32'(d_ack[0]), 32'h1);
        cyc(); d_req = 0; @(negedge clk);
        cmp("d2 core next", 32'(owner[0]), 32'h1);
        cmp("d2 core s_req", 32'(s_req[0]), 32'h1);
        cmp("d2 c_ack", 32'(c_ack[0]), 32'h1);
        cyc(); c_req = 0; s_ack = 0; @(negedge clk);
        cmp("d2 end owner", 32'(owner[0]), 32'h0);

        // Round-robin, both masters requesting continuously
        cyc(); c_req = 1; d_req = 1; s_ack = 1; @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            cyc(); @(negedge clk);
            cmp($sformatf("d3 rr grant %0d", i), 32'(owner[1]), (i % 2 == 0) ? 32'h2 : 32'h1);
        end
        cyc(); c_req = 0; d_req = 0;
        cyc(); s_ack = 0;
        cyc();

        // Debug write fields routed downstream
        c_addr = 32'hFFFF_0000; c_wdata = 32'hAAAA_5555; c_wstrb = 4'b1100;
        d_req = 1; d_we = 1; d_addr = 32'h0000_0010; d_wdata = 32'h1234_5678; d_wstrb = 4'b0011;
        cyc(); @(negedge clk);
        cmp("d4 owner", 32'(owner[0]), 32'h2);
        cmp("d4 s_we", 32'(s_we[0]), 32'h1);
        cmp("d4 s_addr", s_addr[0], 32'h0000_0010);
        cmp("d4 s_wdata", s_wdata[0], 32'h1234_5678);
        cmp("d4 s_wstrb", 32'(s_wstrb[0]), 32'h3);
        cyc(); s_ack = 1; @(negedge clk);
        cmp("d4 d_ack", 32'(d_ack[0]), 32'h1);
        cyc(); d_req = 0; d_we = 0; s_ack = 0;
        cyc();

        // Timeout abort with TIMEOUT=4, late ack ignored
        c_req = 1; s_rdata = 32'hDEAD_BEEF;
        cyc(); cyc(); cyc(); @(negedge clk);
        cmp("d5 cycle3 c_ack", 32'(c_ack[0]), 32'h0);
        cyc(); @(negedge clk);
        cmp("d5 abort c_ack", 32'(c_ack[0]), 32'h1);
        cmp("d5 abort c_err", 32'(c_err[0]), 32'h1);
        cmp("d5 abort c_rdata", c_rdata[0], 32'h0);
        cyc(); c_req = 0; s_ack = 1; @(negedge clk);
        cmp("d5 after owner", 32'(owner[0]), 32'h0);
        cmp("d5 after s_req", 32'(s_req[0]), 32'h0);
        cmp("d5 late c_ack", 32'(c_ack[0]), 32'h0);
        cyc(); s_ack = 0; s_rdata = '0;
        cyc();

        // Reset in the middle of a core access
        c_req = 1;
        cyc(); @(negedge clk);
        cmp("d6 pre owner", 32'(owner[0]), 32'h1);
        cyc(); d_req = 1; rst = 1; #1;
        cmp("d6 rst owner", 32'(owner[0]), 32'h0);
        cmp("d6 rst s_req", 32'(s_req[0]), 32'h0);
        cmp("d6 rst c_ack", 32'(c_ack[0]), 32'h0);
        cyc(); rst = 0; c_req = 0;
        cyc(); @(negedge clk);
        cmp("d6 dm granted", 32'(owner[0]), 32'h2);
        cyc(); s_ack = 1; d_req = 0;
        cyc(); s_ack = 0;

        // Randomized traffic with varying slave responsiveness
        pct = 50;
        for (int i = 0; i < 4000; i++) begin
            cyc();
            if (i % 40 == 0) begin
                case ($urandom_range(0, 3))
                    0: pct = 5;
                    1: pct = 30;
                    2: pct = 60;
                    default: pct = 95;
                endcase
            end
            if (c_req) begin
                if ($urandom_range(0, 99) < 15) c_req = 0;
            end else if ($urandom_range(0, 99) < 40) begin
                c_req = 1; c_we = 1'($urandom); c_addr = $urandom;
                c_wdata = $urandom; c_wstrb = 4'($urandom);
            end
            if (d_req) begin
                if ($urandom_range(0, 99) < 15) d_req = 0;
            end else if ($urandom_range(0, 99) < 40) begin
                d_req = 1; d_we = 1'($urandom); d_addr = $urandom;
                d_wdata = $urandom; d_wstrb = 4'($urandom);
            end
            s_ack   = ($urandom_range(0, 99) < pct);
            s_rdata = $urandom;
            rst     = ($urandom_range(0, 299) == 0);
        end
        cyc(); rst = 0;
        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
